ped_crossing_ctrl: RTL
======================

# ped_crossing_ctrl

Pedestrian crossing controller that sits directly downstream of the traffic-light controller and consumes its `red`/`yellow`/`green` lamp outputs. It debounces and latches a pedestrian push-button request. When the vehicle light next turns red, it grants a WALK interval and then a flashing DON'T WALK clearance interval with a countdown. It flags a sticky conflict if the vehicle light leaves red during a pedestrian phase, or if the lamp inputs are not one-hot.

## Interface
Parameters:
- `WALK_CYCLES`, default 4: cycles of steady `walk`; legal range 1..15.
- `FLASH_CYCLES`, default 6: cycles of flashing clearance; legal range 1..15.
- `DEBOUNCE`, default 2: consecutive `btn`=1 samples needed to accept a press; legal range 1..7.

Ports:
- `clk`  in  1  Single clock; everything is sampled on its rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `btn`  in  1  Pedestrian button, already synchronous to `clk`.
- `red`  in  1  Vehicle red lamp from the traffic-light controller.
- `yellow`  in  1  Vehicle yellow lamp.
- `green`  in  1  Vehicle green lamp.
- `walk`  out  1  Steady WALK lamp.
- `dont_walk`  out  1  DON'T WALK lamp; steady in idle, toggling in clearance.
- `req_pending`  out  1  A request has been latched and not yet served.
- `countdown`  out  4  Remaining clearance cycles; 0 outside FLASH.
- `conflict`  out  1  Sticky fault flag.

## Operation
- Reset values: `walk`=0, `dont_walk`=1, `req_pending`=0, `countdown`=0, `conflict`=0, state=IDLE, debounce count=0.
- Red-rise detector: `red_q` is a register and resets to 1, so a red phase already in progress at reset is never served. `red_rise` = `red` & ~`red_q`.
- Debounce: a saturating counter increments on each sampled `btn`=1 and clears on `btn`=0.
  - When the counter reaches `DEBOUNCE`, `req_pending` sets. This happens once per press.
  - A new press is accepted only after `btn` has been sampled 0 at least once.
  - Presses are ignored in WALK. They are accepted in IDLE, WAIT and FLASH.
- State machine:
  - IDLE: `dont_walk`=1. Goes to WAIT when `req_pending`=1.
  - WAIT: `dont_walk`=1. Goes to WALK on `red_rise`. The `req_pending` register value is used, not a press set on the same edge.
  - WALK: `walk`=1, `dont_walk`=0, cycle counter loaded with `WALK_CYCLES`. `req_pending` clears on entry. Goes to FLASH after `WALK_CYCLES` cycles.
  - FLASH: `walk`=0. `dont_walk` starts at 1 and toggles every cycle. `countdown` = `FLASH_CYCLES` on the first FLASH cycle and decrements by 1 per cycle down to 1. Goes to IDLE after `FLASH_CYCLES` cycles; if `req_pending`=1 on exit, the next state is WAIT instead.
- Abort: `red`=0 sampled in WALK or FLASH sends the state to IDLE on that edge.
  - `walk`=0, `dont_walk`=1, `countdown`=0.
  - `conflict` sets.
  - A latched request is kept.
- Lamp check: in any state, if {`red`,`yellow`,`green`} is not one-hot, `conflict` sets. This check does not change state, except the abort above when `red`=0.
- `conflict` clears only on `reset`.
- `reset` mid-phase returns every register to its reset value on the same edge.

## Timing
- Press registration: `btn` goes high before edge k. `req_pending`=1 after edge k+`DEBOUNCE`-1.
- WALK start: edge e is the first edge that samples `red`=1 after `red`=0, while in WAIT. `walk`=1 after edge e.
- `walk` stays high for exactly `WALK_CYCLES` cycles, edges e+1 through e+`WALK_CYCLES`.
- FLASH occupies cycles e+`WALK_CYCLES`+1 through e+`WALK_CYCLES`+`FLASH_CYCLES`. After that, `dont_walk` holds steady at 1.
- The abort and `conflict` responses appear one edge after the offending sample.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset with `red`=1 held, then `btn`=1 for 2 cycles -> `req_pending`=1 with no WALK. On the next 0->1 transition of `red`, `walk`=1 for exactly 4 cycles.
- `btn` pulse 1 cycle wide with `DEBOUNCE`=2 -> `req_pending` stays 0. A 2-cycle pulse -> `req_pending`=1 after the second sample.
- Full sequence with defaults and red held for 12 cycles -> `walk` 4 cycles. Then `dont_walk` reads 1,0,1,0,1,0 and `countdown` reads 6,5,4,3,2,1. Then `dont_walk`=1 and `countdown`=0. `conflict`=0 throughout.
- `red` drops on the 2nd WALK cycle -> next edge gives `walk`=0, `dont_walk`=1, `conflict`=1. `conflict` stays 1 until `reset`.
- Press during FLASH -> `req_pending`=1 and the state is WAIT after FLASH. The next red rise starts WALK. A press during WALK leaves `req_pending`=0.
- `red`=`green`=1 for one cycle while IDLE -> `conflict`=1 and the state stays IDLE. `reset` clears `conflict` to 0.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// ============================================================================
// Module      : ped_crossing_ctrl
// Description : Pedestrian crossing controller slaved to the vehicle lamps;
//               debounced request, WALK / flashing clearance, conflict flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 4,
    parameter int FLASH_CYCLES = 6,
    parameter int DEBOUNCE     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [3:0] countdown,
    output logic       conflict
);

    localparam logic [3:0] c_walk_cycles  = 4'(WALK_CYCLES);
    localparam logic [3:0] c_flash_cycles = 4'(FLASH_CYCLES);
    localparam logic [2:0] c_debounce     = 3'(DEBOUNCE);
    localparam logic [2:0] c_debounce_m1  = 3'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WALK  = 2'd2,
        S_FLASH = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_red_q;
    logic [2:0] r_deb_cnt;
    logic       r_req;
    logic [3:0] r_cnt;
    logic       r_walk;
    logic       r_dont_walk;
    logic [3:0] r_countdown;
    logic       r_conflict;

    state_t     w_state;
    logic [2:0] w_deb_cnt;
    logic       w_req;
    logic [3:0] w_cnt;
    logic       w_walk;
    logic       w_dont_walk;
    logic [3:0] w_countdown;
    logic       w_conflict;
    logic       w_press;
    logic       w_red_rise;
    logic       w_lamps_onehot;
    logic [2:0] w_lamps;

    assign w_lamps        = {red, yellow, green};
    assign w_lamps_onehot = (w_lamps == 3'b100) || (w_lamps == 3'b010) ||
                            (w_lamps == 3'b001);
    assign w_red_rise     = red & ~r_red_q;
    // The counter saturates at DEBOUNCE, so a held button yields one press only.
    assign w_press        = btn && (r_deb_cnt == c_debounce_m1);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_walk      = 1'b0;
        w_dont_walk = 1'b1;
        w_countdown = 4'd0;
        w_req       = r_req;
        w_conflict  = r_conflict | ~w_lamps_onehot;

        if (!btn) begin
            w_deb_cnt = 3'd0;
        end else if (r_deb_cnt == c_debounce) begin
            w_deb_cnt = r_deb_cnt;
        end else begin
            w_deb_cnt = r_deb_cnt + 3'd1;
        end

        if (w_press && (r_state != S_WALK)) begin
            w_req = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (r_req) begin
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_red_rise) begin
                    w_state     = S_WALK;
                    w_cnt       = c_walk_cycles;
                    w_walk      = 1'b1;
                    w_dont_walk = 1'b0;
                    w_req       = 1'b0;
                end
            end
            S_WALK: begin
                if (!red) begin
                    w_state    = S_IDLE;
                    w_conflict = 1'b1;
                end else if (r_cnt == 4'd1) begin
                    w_state     = S_FLASH;
                    w_countdown = c_flash_cycles;
                end else begin
                    w_cnt       = r_cnt - 4'd1;
                    w_walk      = 1'b1;
                    w_dont_walk = 1'b0;
                end
            end
            S_FLASH: begin
                // countdown doubles as the clearance timer while flashing.
                if (!red) begin
                    w_state    = S_IDLE;
                    w_conflict = 1'b1;
                end else if (r_countdown == 4'd1) begin
                    w_state = r_req ? S_WAIT : S_IDLE;
                end else begin
                    w_countdown = r_countdown - 4'd1;
                    w_dont_walk = ~r_dont_walk;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_red_q     <= 1'b1;
            r_deb_cnt   <= 3'd0;
            r_req       <= 1'b0;
            r_cnt       <= 4'd0;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_countdown <= 4'd0;
            r_conflict  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_red_q     <= red;
            r_deb_cnt   <= w_deb_cnt;
            r_req       <= w_req;
            r_cnt       <= w_cnt;
            r_walk      <= w_walk;
            r_dont_walk <= w_dont_walk;
            r_countdown <= w_countdown;
            r_conflict  <= w_conflict;
        end
    end

    assign walk        = r_walk;
    assign dont_walk   = r_dont_walk;
    assign req_pending = r_req;
    assign countdown   = r_countdown;
    assign conflict    = r_conflict;

endmodule

`default_nettype wire
